// File: rtl/sc_lane_pkg.sv
// Shared types and codes for the lane scroll controller.
// Optional pause support is built only with SC_LANE_SCROLL_CTRL_PAUSE_EN.
package sc_lane_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3
`ifdef SC_LANE_SCROLL_CTRL_PAUSE_EN
      ,
      ST_PAUSE = 3'd4
`endif
   } state_e;

   localparam logic [1:0] SHIFT_HOLD  = 2'b00;
   localparam logic [1:0] SHIFT_LEFT  = 2'b01;
   localparam logic [1:0] SHIFT_RIGHT = 2'b10;

   localparam logic [1:0] LVL1 = 2'd0;
   localparam logic [1:0] LVL2 = 2'd1;
   localparam logic [1:0] LVL3 = 2'd2;
   localparam logic [1:0] LVL4 = 2'd3;

endpackage

// File: rtl/sc_lane_tick_prescaler.sv
// Free-running 0..period-1 counter with a terminal-count tick.
// clr has priority over en; a period of 1 ticks on every enabled cycle.
module sc_lane_tick_prescaler #(
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] period,
   input  logic          en,
   input  logic          clr,
   output logic          tick
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          term;

   // terminal count: count+1 reaches the period
   always_comb begin
      term    = ({1'b0, count_q} + {{CW{1'b0}}, 1'b1}) >= {1'b0, period};
      tick    = en && term;
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = term ? '0 : count_q + 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

endmodule

// File: rtl/sc_lane_scroll_ctrl.sv
// Lane scroll controller: start/clear/load sequencing and timed shifts.
// Define SC_LANE_SCROLL_CTRL_PAUSE_EN to build the PAUSE state.
module sc_lane_scroll_ctrl
   import sc_lane_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int PERIOD_L1 = 25000000,
   parameter int PERIOD_L2 = 12500000,
   parameter int PERIOD_L3 = 6250000,
   parameter int PERIOD_L4 = 3125000,
   parameter bit DIR_RIGHT = 1'b0
) (
   input  logic                         SC_LaneScrollCtrl_CLOCK_50,
   input  logic                         SC_LaneScrollCtrl_RESET_InHigh,
   input  logic                         SC_LaneScrollCtrl_start_InLow,
   input  logic                         SC_LaneScrollCtrl_stop_InLow,
   input  logic                         SC_LaneScrollCtrl_levelup_InLow,
   input  logic [1:0]                   SC_LaneScrollCtrl_level_In,
   input  logic                         SC_LaneScrollCtrl_pause_InHigh,
   output logic                         SC_LaneScrollCtrl_clear_OutLow,
   output logic                         SC_LaneScrollCtrl_load_OutLow,
   output logic [1:0]                   SC_LaneScrollCtrl_transition_selector_Out,
   output logic [1:0]                   SC_LaneScrollCtrl_shiftselection_Out,
   output logic [$clog2(DATAWIDTH)-1:0] SC_LaneScrollCtrl_pos_Out,
   output logic                         SC_LaneScrollCtrl_running_Out
);

   localparam int PW = $clog2(DATAWIDTH);
   localparam logic [1:0] DIR_CODE = DIR_RIGHT ? SHIFT_RIGHT : SHIFT_LEFT;

   logic clk;
   logic rst;
   logic start;
   logic stop;
   logic lvl_up;
   logic pause_req;
   logic in_pause;

   state_e        state_q;
   state_e        state_d;
   logic [1:0]    level_q;
   logic [1:0]    level_d;
   logic [PW-1:0] pos_q;
   logic [PW-1:0] pos_d;
   logic [31:0]   period;
   logic          ps_en;
   logic          ps_clr;
   logic          tick;
   logic          lvl_take;

   assign clk    = SC_LaneScrollCtrl_CLOCK_50;
   assign rst    = SC_LaneScrollCtrl_RESET_InHigh;
   assign start  = !SC_LaneScrollCtrl_start_InLow;
   assign stop   = !SC_LaneScrollCtrl_stop_InLow;
   assign lvl_up = !SC_LaneScrollCtrl_levelup_InLow;

`ifdef SC_LANE_SCROLL_CTRL_PAUSE_EN
   assign pause_req = SC_LaneScrollCtrl_pause_InHigh;
   assign in_pause  = (state_q == ST_PAUSE);
`else
   logic unused_pause;
   assign unused_pause = SC_LaneScrollCtrl_pause_InHigh;
   assign pause_req    = 1'b0;
   assign in_pause     = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next-state: stop beats levelup, levelup beats pause
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_CLEAR;
         ST_CLEAR: state_d = stop ? ST_IDLE : ST_LOAD;
         ST_LOAD:  state_d = stop ? ST_IDLE : ST_RUN;
         ST_RUN: begin
            if (stop)           state_d = ST_IDLE;
            else if (lvl_up)    state_d = ST_LOAD;
`ifdef SC_LANE_SCROLL_CTRL_PAUSE_EN
            else if (pause_req) state_d = ST_PAUSE;
`endif
         end
`ifdef SC_LANE_SCROLL_CTRL_PAUSE_EN
         ST_PAUSE: begin
            if (stop)            state_d = ST_IDLE;
            else if (lvl_up)     state_d = ST_LOAD;
            else if (!pause_req) state_d = ST_RUN;
         end
`endif
         default:  state_d = ST_IDLE;
      endcase
   end

   // outputs decoded from the current state
   always_comb begin
      SC_LaneScrollCtrl_clear_OutLow            = (state_q != ST_CLEAR);
      SC_LaneScrollCtrl_load_OutLow             = (state_q != ST_LOAD);
      SC_LaneScrollCtrl_transition_selector_Out = level_q;
      SC_LaneScrollCtrl_shiftselection_Out      = tick ? DIR_CODE : SHIFT_HOLD;
      SC_LaneScrollCtrl_pos_Out                 = pos_q;
      SC_LaneScrollCtrl_running_Out             = (state_q == ST_RUN) || in_pause;
   end

   // level latch, period select, prescaler control and position
   always_comb begin
      lvl_take = ((state_q == ST_IDLE) && start) ||
                 (((state_q == ST_RUN) || in_pause) && !stop && lvl_up);
      level_d  = lvl_take ? SC_LaneScrollCtrl_level_In : level_q;
      unique case (level_q)
         LVL1:    period = 32'(PERIOD_L1);
         LVL2:    period = 32'(PERIOD_L2);
         LVL3:    period = 32'(PERIOD_L3);
         LVL4:    period = 32'(PERIOD_L4);
         default: period = 32'(PERIOD_L1);
      endcase
      ps_en  = (state_q == ST_RUN) && !stop && !lvl_up && !rst;
      ps_clr = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
      pos_d  = pos_q;
      if (ps_clr) begin
         pos_d = '0;
      end else if (tick) begin
         pos_d = (pos_q == PW'(DATAWIDTH - 1)) ? '0 : pos_q + 1'b1;
      end
   end

   // level and position registers
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= LVL1;
         pos_q   <= '0;
      end else begin
         level_q <= level_d;
         pos_q   <= pos_d;
      end
   end

   sc_lane_tick_prescaler #(
      .CW(32)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .en     (ps_en),
      .clr    (ps_clr),
      .tick   (tick)
   );

endmodule
